ctrl_pkt_arbiter: RTL and testbench
===================================

CTRL_PKT_ARBITER -- requirements
Module: ctrl_pkt_arbiter

Interface
REQ-001 Parameter: w_pkt, 134, FAST2.0 beat width; [133:132] = 01 head, 11 body, 10 tail.
REQ-002 Parameter: DEPTH, 64, beats per input buffer (power of two).
REQ-003 Parameter: AFULL, 48, buffer occupancy at or above which the input's ready deasserts.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-low.
REQ-006 cin0_data_wr  input  1  beat valid, requester 0 (e.g. firewall action cout).
REQ-007 cin0_data  input  w_pkt  beat, requester 0.
REQ-008 cin0_ready  output  1  requester 0 may start a new packet.
REQ-009 cin1_data_wr / cin1_data / cin1_ready: same widths and meaning as REQ-006 to REQ-008, for requester 1.
REQ-010 cout_data_wr  output  1  merged beat valid.
REQ-011 cout_data  output  w_pkt  merged beat.
REQ-012 cout_ready  input  1  downstream may accept a new packet.
REQ-013 drop_cnt  output  16  count of beats discarded on buffer overflow, both inputs combined.

Function
REQ-014 Each input SHALL write every beat with wr=1 into its own FIFO of DEPTH beats, in the same cycle.
REQ-015 A beat that arrives when its FIFO is full SHALL be discarded, and drop_cnt SHALL increment by 1; if both inputs overflow in the same cycle, drop_cnt SHALL increment by 2.
REQ-016 drop_cnt SHALL saturate at 16'hFFFF.
REQ-017 cinN_ready SHALL be a registered copy of (FIFO usedw < AFULL).
REQ-018 Requesters sample ready only at packet start; the block SHALL accept body beats regardless of ready.
REQ-019 Each input SHALL keep a complete-packet counter: +1 when a tail beat is written, -1 when a tail beat is read; a write and a read in the same cycle leave it unchanged.
REQ-020 The FSM SHALL have states IDLE, SEND0 and SEND1, and SHALL reset to IDLE.
REQ-021 In IDLE, a grant SHALL require cout_ready=1 and a complete-packet count > 0 on the candidate input.
REQ-022 When both inputs are eligible, the grant SHALL go to the input not served last (round-robin); last_grant SHALL reset to 1, so input 0 wins the first tie.
REQ-023 On a grant the FSM SHALL move to SENDn, update last_grant, and issue FIFO reads on consecutive cycles.
REQ-024 While in SENDn the FSM SHALL not sample cout_ready; a started packet SHALL stream one beat per cycle without gaps (packet-atomic).
REQ-025 cout_data and cout_data_wr SHALL be registered; each read beat SHALL appear one cycle after its read.
REQ-026 A tail beat written at cycle T SHALL be visible to the FSM at T+1; the packet's head SHALL then appear on cout at T+3 at the earliest.
REQ-027 On reading the tail beat the FSM SHALL return to IDLE; a new grant SHALL be possible in the next cycle, giving one idle output cycle between packets.
REQ-028 Beats from the two inputs SHALL never interleave on cout, and packet order within each input SHALL be preserved.
REQ-029 Beat contents SHALL pass through unmodified.
REQ-030 Simultaneous write and read on one FIFO SHALL leave usedw unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-031 The block SHALL not detect malformed framing; a head arriving before the previous tail is stored as data.

Reset
REQ-032 While reset=0 at a clock edge, the block SHALL:
- empty both FIFOs and clear both packet counters;
- set FSM=IDLE and last_grant=1;
- drive cout_data_wr=0, cout_data=0 and drop_cnt=0;
- drive cin0_ready=cin1_ready=1.
REQ-033 Reset asserted during SENDn SHALL truncate the output packet without emitting a tail; the first post-reset output SHALL be a head beat.

Verification
REQ-034 Single 4-beat packet on cin0 (head at T, tail at T+3), cout_ready=1 -> cout emits the 4 identical beats at T+6..T+9, with cout_data_wr high for exactly 4 cycles.
REQ-035 Both inputs hold a complete 3-beat packet at the same edge after reset -> cin0 packet first, 1 idle cycle, then cin1 packet; repeat -> order alternates 0,1,0,1.
REQ-036 cout_ready=0 with packets buffered -> no output; raise cout_ready mid-run then drop it during a packet -> the started packet completes contiguously and no new packet starts until ready=1.
REQ-037 Push 48 beats into cin0 while cout_ready=0 -> cin0_ready=0 one cycle after usedw reaches 48; 20 more beats -> 4 dropped, drop_cnt=4.
REQ-038 Assert reset for 1 cycle while the 2nd beat of a cin1 packet is on cout -> next cycle cout_data_wr=0, readies=1 and drop_cnt=0; a fresh cin0 packet afterwards is output intact.

Source files
------------

// File: rtl/ctrl_pkt_arbiter.sv
// Two-input FAST2.0 packet arbiter: per-input FIFOs, round-robin, packet-atomic merge onto cout.
// Tail write to head on cout is 3 cycles; cinN_ready is advisory at packet start, overflow beats are dropped and counted.

module ctrl_pkt_fifo #(
  parameter int W     = 134,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr,
  input  logic [W-1:0]           i_dat,
  input  logic                   i_rd,
  output logic [W-1:0]           o_dat,
  output logic [$clog2(DEPTH):0] o_usedw,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PONE  = (AW)'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_usedw;
  logic          w_we, w_re;

  assign o_full  = (r_usedw == LP_DEPTH);
  assign o_empty = (r_usedw == '0);
  assign w_we    = i_wr & ~o_full;
  assign w_re    = i_rd & ~o_empty;
  assign o_dat   = r_mem[r_rptr];
  assign o_usedw = r_usedw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usedw <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + LP_PONE;
      if (w_re) r_rptr <= r_rptr + LP_PONE;
      case ({w_we, w_re})
        2'b10:   r_usedw <= r_usedw + LP_ONE;
        2'b01:   r_usedw <= r_usedw - LP_ONE;
        default: r_usedw <= r_usedw;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr] <= i_dat;
  end
endmodule

module ctrl_pkt_arbiter #(
  parameter int w_pkt = 134,
  parameter int DEPTH = 64,
  parameter int AFULL = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cin0_data_wr,
  input  logic [w_pkt-1:0] cin0_data,
  output logic             cin0_ready,
  input  logic             cin1_data_wr,
  input  logic [w_pkt-1:0] cin1_data,
  output logic             cin1_ready,
  output logic             cout_data_wr,
  output logic [w_pkt-1:0] cout_data,
  input  logic             cout_ready,
  output logic [15:0]      drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL);
  localparam logic [1:0]  TAIL     = 2'b10;

  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

  state_t           r_state, w_next;
  logic             r_last_grant;
  logic             w_rd0, w_rd1;
  logic [w_pkt-1:0] w_q0, w_q1;
  logic [AW:0]      w_used0, w_used1;
  logic             w_full0, w_full1, w_empty0, w_empty1;
  logic [AW:0]      r_pkts0, r_pkts1;
  logic             r_ready0, r_ready1;
  logic             r_cout_wr;
  logic [w_pkt-1:0] r_cout_data;
  logic [15:0]      r_drop_cnt;
  logic             w_drop0, w_drop1;
  logic             w_tail_wr0, w_tail_wr1, w_tail_rd0, w_tail_rd1;
  logic [16:0]      w_drop_sum;

  ctrl_pkt_fifo #(.W(w_pkt), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .i_wr(cin0_data_wr), .i_dat(cin0_data), .i_rd(w_rd0),
    .o_dat(w_q0), .o_usedw(w_used0), .o_full(w_full0), .o_empty(w_empty0)
  );

  ctrl_pkt_fifo #(.W(w_pkt), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .i_wr(cin1_data_wr), .i_dat(cin1_data), .i_rd(w_rd1),
    .o_dat(w_q1), .o_usedw(w_used1), .o_full(w_full1), .o_empty(w_empty1)
  );

  // Only accepted tails count as complete packets; a dropped tail never becomes grantable.
  assign w_drop0    = cin0_data_wr & w_full0;
  assign w_drop1    = cin1_data_wr & w_full1;
  assign w_tail_wr0 = cin0_data_wr & ~w_full0 & (cin0_data[w_pkt-1 -: 2] == TAIL);
  assign w_tail_wr1 = cin1_data_wr & ~w_full1 & (cin1_data[w_pkt-1 -: 2] == TAIL);
  assign w_tail_rd0 = w_rd0 & (w_q0[w_pkt-1 -: 2] == TAIL);
  assign w_tail_rd1 = w_rd1 & (w_q1[w_pkt-1 -: 2] == TAIL);
  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop0) + 17'(w_drop1);

  always_comb begin
    w_next = r_state;
    w_rd0  = 1'b0;
    w_rd1  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cout_ready) begin
          if ((r_pkts0 != '0) && ((r_pkts1 == '0) || r_last_grant)) w_next = SEND0;
          else if (r_pkts1 != '0)                                   w_next = SEND1;
        end
      end
      SEND0: begin
        w_rd0 = ~w_empty0;
        if (~w_empty0 && (w_q0[w_pkt-1 -: 2] == TAIL)) w_next = IDLE;
      end
      SEND1: begin
        w_rd1 = ~w_empty1;
        if (~w_empty1 && (w_q1[w_pkt-1 -: 2] == TAIL)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_pkts0      <= '0;
      r_pkts1      <= '0;
      r_ready0     <= 1'b1;
      r_ready1     <= 1'b1;
      r_cout_wr    <= 1'b0;
      r_cout_data  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == SEND0) r_last_grant <= 1'b0;
      if (r_state == IDLE && w_next == SEND1) r_last_grant <= 1'b1;
      r_pkts0  <= r_pkts0 + (AW+1)'(w_tail_wr0) - (AW+1)'(w_tail_rd0);
      r_pkts1  <= r_pkts1 + (AW+1)'(w_tail_wr1) - (AW+1)'(w_tail_rd1);
      r_ready0 <= (w_used0 < LP_AFULL);
      r_ready1 <= (w_used1 < LP_AFULL);
      r_cout_wr <= w_rd0 | w_rd1;
      if (w_rd0)      r_cout_data <= w_q0;
      else if (w_rd1) r_cout_data <= w_q1;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign cin0_ready   = r_ready0;
  assign cin1_ready   = r_ready1;
  assign cout_data_wr = r_cout_wr;
  assign cout_data    = r_cout_data;
  assign drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// Bench for ctrl_pkt_arbiter: scenario tasks against a queue-based reference model.
module tb_ctrl_pkt_arbiter;
  localparam int W = 134;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cin0_data_wr = 1'b0, cin1_data_wr = 1'b0, cout_ready = 1'b0;
  logic [W-1:0] cin0_data = '0, cin1_data = '0;
  logic         cin0_ready, cin1_ready, cout_data_wr;
  logic [W-1:0] cout_data;
  logic [15:0]  drop_cnt;

  ctrl_pkt_arbiter #(.w_pkt(W), .DEPTH(64), .AFULL(48)) dut (
    .clk(clk), .reset(reset),
    .cin0_data_wr(cin0_data_wr), .cin0_data(cin0_data), .cin0_ready(cin0_ready),
    .cin1_data_wr(cin1_data_wr), .cin1_data(cin1_data), .cin1_ready(cin1_ready),
    .cout_data_wr(cout_data_wr), .cout_data(cout_data), .cout_ready(cout_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Output log: beat and the edge index at which a downstream sampler sees it.
  logic [W-1:0] mon_dat[$];
  int           mon_cyc[$];
  always @(negedge clk) begin
    if (cout_data_wr === 1'b1) begin
      mon_dat.push_back(cout_data);
      mon_cyc.push_back(cyc_n + 1);
    end
  end

  logic [W-1:0] exp0[$], exp1[$];
  int m_used0 = 0, m_used1 = 0, m_drop = 0, m_last = 1;
  int n_tests = 0, n_fail = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk_beat(input logic [1:0] typ, input logic src);
    logic [127:0] a;
    logic [2:0]   b;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = 3'($urandom_range(0, 7));
    return {typ, src, b, a};
  endfunction

  function automatic logic [1:0] typ_of(input int i, input int n);
    if (i == 0) return 2'b01;
    if (i == n - 1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w0, input logic [W-1:0] d0, input logic w1, input logic [W-1:0] d1);
    cin0_data_wr = w0; cin0_data = d0;
    cin1_data_wr = w1; cin1_data = d1;
    if (w0) begin
      if (m_used0 >= 64) m_drop++;
      else begin m_used0++; exp0.push_back(d0); end
    end
    if (w1) begin
      if (m_used1 >= 64) m_drop++;
      else begin m_used1++; exp1.push_back(d1); end
    end
    tick();
    cin0_data_wr = 1'b0;
    cin1_data_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp0.delete(); exp1.delete();
    mon_dat.delete(); mon_cyc.delete();
    m_used0 = 0; m_used1 = 0; m_drop = 0; m_last = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_tests++; if (cout_data_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", cout_data_wr); end
    n_tests++; if (cout_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", cout_data); end
    n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_tests++; if (cin0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy0: got %b want 1", cin0_ready); end
    n_tests++; if (cin1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy1: got %b want 1", cin1_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [W-1:0] e;
    int t0;
    mon_dat.delete(); mon_cyc.delete();
    cout_ready = 1'b1;
    t0 = cyc_n + 1;
    for (int i = 0; i < 4; i++) drive(1'b1, mk_beat(typ_of(i, 4), 1'b0), 1'b0, '0);
    repeat (14) tick();
    n_tests++; if (mon_dat.size() != 4) begin n_fail++; $display("FAIL single_count: got %0d beats want 4", mon_dat.size()); end
    for (int i = 0; i < 4 && i < mon_dat.size(); i++) begin
      e = exp0.pop_front();
      n_tests++; if (mon_dat[i] !== e) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, mon_dat[i], e); end
      n_tests++; if (mon_cyc[i] != t0 + 6 + i) begin n_fail++; $display("FAIL single_time[%0d]: got %0d want %0d", i, mon_cyc[i], t0 + 6 + i); end
    end
    exp0.delete(); m_used0 = 0; m_last = 0;
  endtask

  task automatic test_tie_rr();
    logic [W-1:0] e;
    int t0, src, idx;
    do_reset();
    cout_ready = 1'b1;
    t0 = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 3; i++) begin
        if (p == 0 && i == 2) t0 = cyc_n + 1;
        drive(1'b1, mk_beat(typ_of(i, 3), 1'b0), 1'b1, mk_beat(typ_of(i, 3), 1'b1));
      end
    repeat (25) tick();
    n_tests++; if (mon_dat.size() != 12) begin n_fail++; $display("FAIL tie_count: got %0d beats want 12", mon_dat.size()); end
    for (int k = 0; k < 4; k++) begin
      src = (m_last == 1) ? 0 : 1;
      for (int i = 0; i < 3; i++) begin
        idx = k * 3 + i;
        e = (src == 1) ? exp1.pop_front() : exp0.pop_front();
        if (idx < mon_dat.size()) begin
          n_tests++; if (mon_dat[idx] !== e) begin n_fail++; $display("FAIL tie_data[%0d]: got %h want %h", idx, mon_dat[idx], e); end
          n_tests++; if (mon_cyc[idx] != t0 + 3 + idx + k) begin n_fail++; $display("FAIL tie_time[%0d]: got %0d want %0d", idx, mon_cyc[idx], t0 + 3 + idx + k); end
        end
      end
      m_last = src;
    end
    m_used0 = 0; m_used1 = 0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    int src;
    mon_dat.delete(); mon_cyc.delete();
    cout_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, mk_beat(typ_of(i, 4), 1'b0), 1'b1, mk_beat(typ_of(i, 4), 1'b1));
    repeat (10) tick();
    n_tests++; if (mon_dat.size() != 0) begin n_fail++; $display("FAIL bp_hold: got %0d beats want 0", mon_dat.size()); end
    cout_ready = 1'b1;
    tick(); tick();
    cout_ready = 1'b0;
    repeat (15) tick();
    n_tests++; if (mon_dat.size() != 4) begin n_fail++; $display("FAIL bp_first_count: got %0d beats want 4", mon_dat.size()); end
    cout_ready = 1'b1;
    repeat (12) tick();
    n_tests++; if (mon_dat.size() != 8) begin n_fail++; $display("FAIL bp_second_count: got %0d beats want 8", mon_dat.size()); end
    for (int k = 0; k < 2; k++) begin
      src = (m_last == 1) ? 0 : 1;
      for (int i = k * 4; i < k * 4 + 4 && i < mon_dat.size(); i++) begin
        e = (src == 1) ? exp1.pop_front() : exp0.pop_front();
        n_tests++; if (mon_dat[i] !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, mon_dat[i], e); end
        if (i != k * 4) begin
          n_tests++; if (mon_cyc[i] != mon_cyc[i-1] + 1) begin n_fail++; $display("FAIL bp_gap[%0d]: got cycle %0d want %0d", i, mon_cyc[i], mon_cyc[i-1] + 1); end
        end
      end
      m_last = src;
    end
    exp0.delete(); exp1.delete(); m_used0 = 0; m_used1 = 0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    logic [1:0]   t;
    bit           ok;
    mon_dat.delete(); mon_cyc.delete();
    cout_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, mk_beat(typ_of(i, 4), 1'b1));
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (mon_dat.size() >= 2) begin ok = 1'b1; break; end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_wait: got %0d beats want 2 within 20 cycles", mon_dat.size()); end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n_tests++; if (cout_data_wr !== 1'b0) begin n_fail++; $display("FAIL rmid_wr: got %b want 0", cout_data_wr); end
    n_tests++; if (cout_data !== '0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", cout_data); end
    n_tests++; if (cin0_ready !== 1'b1 || cin1_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_rdy: got %b%b want 11", cin0_ready, cin1_ready); end
    n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt); end
    exp0.delete(); exp1.delete(); m_used0 = 0; m_used1 = 0; m_last = 1;
    repeat (10) tick();
    n_tests++; if (mon_dat.size() != 2) begin n_fail++; $display("FAIL rmid_trunc: got %0d beats want 2", mon_dat.size()); end
    mon_dat.delete(); mon_cyc.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, mk_beat(typ_of(i, 4), 1'b0), 1'b0, '0);
    repeat (14) tick();
    n_tests++; if (mon_dat.size() != 4) begin n_fail++; $display("FAIL rmid_after_count: got %0d beats want 4", mon_dat.size()); end
    if (mon_dat.size() > 0) begin
      e = mon_dat[0];
      t = e[W-1 -: 2];
      n_tests++; if (t !== 2'b01) begin n_fail++; $display("FAIL rmid_head: got type %b want 01", t); end
    end
    for (int i = 0; i < 4 && i < mon_dat.size(); i++) begin
      e = exp0.pop_front();
      n_tests++; if (mon_dat[i] !== e) begin n_fail++; $display("FAIL rmid_data[%0d]: got %h want %h", i, mon_dat[i], e); end
    end
    exp0.delete(); m_used0 = 0; m_last = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    cout_ready = 1'b0;
    for (int i = 0; i < 48; i++) drive(1'b1, mk_beat(2'b11, 1'b0), 1'b0, '0);
    n_tests++; if (cin0_ready !== ((m_used0 - 1) < 48)) begin n_fail++; $display("FAIL ovf_rdy_lag: got %b want %b", cin0_ready, (m_used0 - 1) < 48); end
    tick();
    n_tests++; if (cin0_ready !== (m_used0 < 48)) begin n_fail++; $display("FAIL ovf_rdy_low: got %b want %b", cin0_ready, m_used0 < 48); end
    for (int i = 0; i < 20; i++) drive(1'b1, mk_beat(2'b11, 1'b0), 1'b0, '0);
    n_tests++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL ovf_drop0: got %0d want %0d", drop_cnt, m_drop); end
    for (int i = 0; i < 64; i++) drive(1'b0, '0, 1'b1, mk_beat(2'b11, 1'b1));
    drive(1'b1, mk_beat(2'b11, 1'b0), 1'b1, mk_beat(2'b11, 1'b1));
    n_tests++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL ovf_drop_dual: got %0d want %0d", drop_cnt, m_drop); end
    for (int i = 0; i < 2; i++) drive(1'b1, mk_beat(2'b11, 1'b0), 1'b1, mk_beat(2'b11, 1'b1));
    n_tests++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL ovf_drop_total: got %0d want %0d", drop_cnt, m_drop); end
    n_tests++; if (cin1_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy1: got %b want 0", cin1_ready); end
    n_tests++; if (mon_dat.size() != 0) begin n_fail++; $display("FAIL ovf_no_out: got %0d beats want 0", mon_dat.size()); end
    do_reset();
  endtask

  task automatic test_random();
    logic [W:0]   s0[$], s1[$];
    logic [W:0]   a, b;
    logic [W-1:0] bt, e;
    int np, n, gap, len, src;
    bit inpkt;
    for (int r = 0; r < 6; r++) begin
      s0.delete(); s1.delete();
      mon_dat.delete(); mon_cyc.delete();
      for (int k = 0; k < 2; k++) begin
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) begin
          gap = $urandom_range(0, 2);
          n   = $urandom_range(2, 6);
          for (int g = 0; g < gap; g++) begin
            if (k == 0) s0.push_back('0); else s1.push_back('0);
          end
          for (int i = 0; i < n; i++) begin
            if (k == 0) s0.push_back({1'b1, mk_beat(typ_of(i, n), 1'b0)});
            else        s1.push_back({1'b1, mk_beat(typ_of(i, n), 1'b1)});
          end
        end
      end
      len = (s0.size() > s1.size()) ? s0.size() : s1.size();
      for (int c = 0; c < len; c++) begin
        a = (c < s0.size()) ? s0[c] : '0;
        b = (c < s1.size()) ? s1[c] : '0;
        cout_ready = 1'($urandom_range(0, 1));
        drive(a[W], a[W-1:0], b[W], b[W-1:0]);
      end
      cout_ready = 1'b1;
      repeat (80) tick();
      inpkt = 1'b0; src = 0;
      for (int i = 0; i < mon_dat.size(); i++) begin
        bt = mon_dat[i];
        if (bt[W-1 -: 2] == 2'b01) begin
          n_tests++; if (inpkt) begin n_fail++; $display("FAIL rnd_interleave[%0d]: got head inside packet want tail first", i); end
          if (i > 0) begin
            n_tests++; if (mon_cyc[i] < mon_cyc[i-1] + 2) begin n_fail++; $display("FAIL rnd_idle[%0d]: got cycle %0d want >= %0d", i, mon_cyc[i], mon_cyc[i-1] + 2); end
          end
          src = int'(bt[W-3]); inpkt = 1'b1;
        end else begin
          n_tests++; if (!inpkt || i == 0 || mon_cyc[i] != mon_cyc[i-1] + 1) begin n_fail++; $display("FAIL rnd_contig[%0d]: got cycle %0d want contiguous", i, mon_cyc[i]); end
        end
        n_tests++;
        if ((src == 0 && exp0.size() == 0) || (src == 1 && exp1.size() == 0)) begin
          n_fail++; $display("FAIL rnd_extra[%0d]: got %h want no beat", i, bt);
        end else begin
          e = (src == 1) ? exp1.pop_front() : exp0.pop_front();
          if (bt !== e) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, bt, e); end
        end
        if (bt[W-1 -: 2] == 2'b10) inpkt = 1'b0;
      end
      n_tests++; if (exp0.size() != 0 || exp1.size() != 0) begin n_fail++; $display("FAIL rnd_left: got %0d/%0d beats undelivered want 0/0", exp0.size(), exp1.size()); end
      exp0.delete(); exp1.delete();
      m_used0 = 0; m_used1 = 0;
    end
    n_tests++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_drop: got %0d want %0d", drop_cnt, m_drop); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_rr();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
